gfx_addr_pipe: RTL and testbench

GFX_ADDR_PIPE -- requirements
Module: gfx_addr_pipe

---
 rtl/gfx_addr_pipe.sv | 186 ++++++++++++++++++
 tb/tb_gfx_addr_pipe.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gfx_addr_pipe.sv
// Pixel (x,y) to packed-strip byte address and mask-bit pipeline, three register stages,
// with a strip-count cache that drains the pipe and recomputes whenever the bitmap geometry changes.
module gfx_addr_pipe #(
    parameter int SW = 128,
    parameter int BN = 6,
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    color_depth_i,
    input  logic [15:0]   bmp_width_i,
    output logic          cfg_busy_o,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [AW-1:0] base_address_i,
    input  logic [15:0]   x_coord_i,
    input  logic [15:0]   y_coord_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [AW-1:0] address_o,
    output logic [BN:0]   mb_o,
    output logic [BN:0]   me_o,
    output logic [BN:0]   ce_o
);
    localparam int SH = $clog2(SW / 8);
    localparam int MW = BN + 1;

    typedef enum logic [1:0] {
        CALC  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic logic [5:0] bits_of(input logic [1:0] d);
        case (d)
            2'd0:    bits_of = 6'd8;
            2'd1:    bits_of = 6'd16;
            2'd2:    bits_of = 6'd24;
            2'd3:    bits_of = 6'd32;
            default: bits_of = 6'd8;
        endcase
    endfunction

    function automatic logic [5:0] cbits_of(input logic [1:0] d);
        case (d)
            2'd0:    cbits_of = 6'd5;
            2'd1:    cbits_of = 6'd12;
            2'd2:    cbits_of = 6'd21;
            2'd3:    cbits_of = 6'd27;
            default: cbits_of = 6'd5;
        endcase
    endfunction

    // Strips per pixel in 0.16 fixed point: 65536*bits/SW.
    function automatic logic [15:0] coeff_of(input logic [1:0] d);
        logic [31:0] num;
        num = {10'd0, bits_of(d), 16'd0};
        coeff_of = 16'(num / 32'(SW));
    endfunction

    // Number of bits actually used per strip (whole pixels only).
    function automatic logic [9:0] coeff2_of(input logic [1:0] d);
        logic [31:0] sw;
        logic [31:0] b;
        sw = 32'(SW);
        b  = {26'd0, bits_of(d)};
        coeff2_of = 10'(sw - (sw % b));
    endfunction

    state_t          state_q;
    logic [15:0]     width_q;
    logic [1:0]      depth_q;
    logic [15:0]     nstrips_q;

    logic            v1_q, v2_q, v3_q;
    logic [31:0]     p1_q, nsy1_q;
    logic [AW-1:0]   base1_q, base2_q, addr3_q;
    logic [18:0]     prod2_q;
    logic [32:0]     sum2_q;
    logic [BN:0]     mb3_q, me3_q, ce3_q;

    logic            adv_s, mismatch_s, accept_s;
    logic [31:0]     nstrips_prod_s;
    logic [31:0]     p1_d, nsy1_d;
    logic [15:0]     f_s;
    logic [18:0]     prod2_d;
    logic [32:0]     sum2_d;
    logic [32+SH:0]  off_s;
    logic [AW-1:0]   addr3_d;
    logic [BN:0]     mb3_d, me3_d, ce3_d;
    logic [5:0]      bits_s, cbits_s;

    // Handshake, busy flag and fresh strip count from the live configuration.
    always_comb begin
        adv_s          = !v3_q || out_ready_i;
        mismatch_s     = (bmp_width_i != width_q) || (color_depth_i != depth_q);
        in_ready_o     = adv_s && (state_q == RUN) && !mismatch_s;
        accept_s       = in_valid_i && in_ready_o;
        cfg_busy_o     = (state_q != RUN);
        nstrips_prod_s = 32'(bmp_width_i) * 32'(coeff_of(color_depth_i));
    end

    // Stage datapath; everything depends only on the captured depth, never the live one.
    always_comb begin
        bits_s  = bits_of(depth_q);
        cbits_s = cbits_of(depth_q);
        p1_d    = 32'(x_coord_i) * 32'(coeff_of(depth_q));
        nsy1_d  = 32'(nstrips_q) * 32'(y_coord_i);
        f_s     = p1_q[15:0] + 16'h007F;
        prod2_d = 19'(f_s >> 7) * 19'(coeff2_of(depth_q));
        sum2_d  = {1'b0, nsy1_q} + {17'd0, p1_q[31:16]};
        mb3_d   = MW'(prod2_q >> 9);
        me3_d   = mb3_d + MW'(bits_s - 6'd1);
        ce3_d   = mb3_d + MW'(cbits_s - 6'd1);
        off_s   = {sum2_q, {SH{1'b0}}};
        addr3_d = base2_q + AW'(off_s);
    end

    // Configuration cache FSM: recompute only once the pipe holds no entry of the old geometry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= CALC;
            width_q   <= 16'd0;
            depth_q   <= 2'd0;
            nstrips_q <= 16'd0;
        end else begin
            case (state_q)
                CALC: begin
                    width_q   <= bmp_width_i;
                    depth_q   <= color_depth_i;
                    nstrips_q <= 16'(nstrips_prod_s >> 16);
                    state_q   <= RUN;
                end
                RUN: begin
                    if (mismatch_s) state_q <= DRAIN;
                    else            state_q <= RUN;
                end
                DRAIN: begin
                    if (!(v1_q || v2_q || v3_q)) state_q <= CALC;
                    else                         state_q <= DRAIN;
                end
                default: state_q <= CALC;
            endcase
        end
    end

    // Lock-step pipeline: all stages shift together, bubbles included.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            p1_q    <= 32'd0;
            nsy1_q  <= 32'd0;
            base1_q <= '0;
            prod2_q <= 19'd0;
            sum2_q  <= 33'd0;
            base2_q <= '0;
            addr3_q <= '0;
            mb3_q   <= '0;
            me3_q   <= '0;
            ce3_q   <= '0;
        end else if (adv_s) begin
            v1_q    <= accept_s;
            p1_q    <= p1_d;
            nsy1_q  <= nsy1_d;
            base1_q <= base_address_i;
            v2_q    <= v1_q;
            prod2_q <= prod2_d;
            sum2_q  <= sum2_d;
            base2_q <= base1_q;
            v3_q    <= v2_q;
            addr3_q <= addr3_d;
            mb3_q   <= mb3_d;
            me3_q   <= me3_d;
            ce3_q   <= ce3_d;
        end
    end

    assign out_valid_o = v3_q;
    assign address_o   = addr3_q;
    assign mb_o        = mb3_q;
    assign me_o        = me3_q;
    assign ce_o        = ce3_q;

endmodule

// File: tb/tb_gfx_addr_pipe.sv
// Bench for gfx_addr_pipe: directed scenarios plus random traffic, every result scored
// against an arithmetic model of the address/mask rules and a latency rule derived from stalls.
module tb_gfx_addr_pipe;
    localparam int SW = 128;
    localparam int BN = 6;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    color_depth_i;
    logic [15:0]   bmp_width_i;
    logic          cfg_busy_o;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [AW-1:0] base_address_i;
    logic [15:0]   x_coord_i;
    logic [15:0]   y_coord_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [AW-1:0] address_o;
    logic [BN:0]   mb_o, me_o, ce_o;

    gfx_addr_pipe #(.SW(SW), .BN(BN), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .color_depth_i(color_depth_i), .bmp_width_i(bmp_width_i), .cfg_busy_o(cfg_busy_o),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .base_address_i(base_address_i), .x_coord_i(x_coord_i), .y_coord_i(y_coord_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .address_o(address_o), .mb_o(mb_o), .me_o(me_o), .ce_o(ce_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] mb;
        logic [63:0] me;
        logic [63:0] ce;
        int          cyc;
        int          stall;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          stall_cnt = 0;
    int          n_checks = 0;
    int          n_err = 0;
    logic        stall_prev = 1'b0;
    logic [63:0] hold_addr, hold_mb, hold_me, hold_ce;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
        end
    endtask

    // Result of one request computed straight from the address/mask formulas.
    function automatic exp_t model(input logic [1:0] d, input logic [15:0] w, input logic [AW-1:0] b,
                                   input logic [15:0] x, input logic [15:0] y);
        exp_t        e;
        logic [63:0] bits, cbits, coeff, coeff2, p, f, ns;
        bits = 64'd8 * (64'(d) + 64'd1);
        case (d)
            2'd0:    cbits = 64'd5;
            2'd1:    cbits = 64'd12;
            2'd2:    cbits = 64'd21;
            default: cbits = 64'd27;
        endcase
        coeff  = (64'd65536 * bits) / 64'(SW);
        coeff2 = 64'(SW) - (64'(SW) % bits);
        p      = 64'(x) * coeff;
        f      = ((p % 64'd65536) + 64'd127) % 64'd65536;
        ns     = (64'(w) * coeff) / 64'd65536;
        e.mb   = (((f / 64'd128) * coeff2) / 64'd512) % 64'(SW);
        e.me   = (e.mb + bits - 64'd1) % 64'(SW);
        e.ce   = (e.mb + cbits - 64'd1) % 64'(SW);
        e.addr = (64'(b) + (ns * 64'(y) + p / 64'd65536) * 64'(SW / 8)) % (64'd1 << AW);
        e.cyc   = 0;
        e.stall = 0;
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: accepted requests in, delivered results out, stalls must freeze the outputs.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q.delete();
            stall_prev = 1'b0;
            chk("rst_out_valid", 64'(out_valid_o), 64'd0);
            chk("rst_in_ready", 64'(in_ready_o), 64'd0);
            chk("rst_busy", 64'(cfg_busy_o), 64'd1);
            chk("rst_addr", 64'(address_o), 64'd0);
            chk("rst_mb", 64'(mb_o), 64'd0);
            chk("rst_me", 64'(me_o), 64'd0);
            chk("rst_ce", 64'(ce_o), 64'd0);
        end else begin
            if (stall_prev) begin
                chk("hold_valid", 64'(out_valid_o), 64'd1);
                chk("hold_addr", 64'(address_o), hold_addr);
                chk("hold_mb", 64'(mb_o), hold_mb);
                chk("hold_me", 64'(me_o), hold_me);
                chk("hold_ce", 64'(ce_o), hold_ce);
            end
            if (out_valid_o && !out_ready_i)
                chk("stall_in_ready", 64'(in_ready_o), 64'd0);
            if (out_valid_o && out_ready_i) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_out: result addr 0x%0h delivered, expected none pending", address_o);
                end else begin
                    e = q.pop_front();
                    chk("addr", 64'(address_o), e.addr);
                    chk("mb", 64'(mb_o), e.mb);
                    chk("me", 64'(me_o), e.me);
                    chk("ce", 64'(ce_o), e.ce);
                    chk("latency", 64'(cyc - e.cyc), 64'(3 + stall_cnt - e.stall));
                end
            end
            if (in_valid_i && in_ready_o) begin
                e = model(color_depth_i, bmp_width_i, base_address_i, x_coord_i, y_coord_i);
                e.cyc   = cyc;
                e.stall = stall_cnt;
                q.push_back(e);
            end
            if (out_valid_o && !out_ready_i) stall_cnt++;
            stall_prev = out_valid_o && !out_ready_i;
            hold_addr  = 64'(address_o);
            hold_mb    = 64'(mb_o);
            hold_me    = 64'(me_o);
            hold_ce    = 64'(ce_o);
        end
    end

    task automatic send(input logic [AW-1:0] b, input logic [15:0] x, input logic [15:0] y,
                        output int waited);
        base_address_i = b;
        x_coord_i      = x;
        y_coord_i      = y;
        in_valid_i     = 1'b1;
        waited         = 0;
        @(negedge clk);
        while (!in_ready_o && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (!in_ready_o) begin
            n_err++;
            $display("FAIL send_timeout: in_ready_o still 0 after %0d cycles, required 1", waited);
        end
        @(posedge clk); #1;
        in_valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid_i = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic release_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("calc_in_ready", 64'(in_ready_o), 64'd0);
        chk("calc_busy", 64'(cfg_busy_o), 64'd1);
        @(negedge clk);
        chk("run_in_ready", 64'(in_ready_o), 64'd1);
        chk("run_busy", 64'(cfg_busy_o), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        exp_t e;
        int   w;
        int   busy_n;
        int   last_out;
        int   first_rdy;

        color_depth_i  = 2'd1;
        bmp_width_i    = 16'd640;
        in_valid_i     = 1'b0;
        base_address_i = '0;
        x_coord_i      = 16'd0;
        y_coord_i      = 16'd0;
        out_ready_i    = 1'b1;

        e = model(2'd1, 16'd640, 32'h1000_0000, 16'd10, 16'd3);
        chk("pin_bpp16_addr", e.addr, 64'h1000_0F10);
        chk("pin_bpp16_mb", e.mb, 64'd32);
        chk("pin_bpp16_me", e.me, 64'd47);
        chk("pin_bpp16_ce", e.ce, 64'd43);
        e = model(2'd3, 16'd640, 32'h0, 16'd7, 16'd0);
        chk("pin_bpp32_addr", e.addr, 64'h10);
        chk("pin_bpp32_mb", e.mb, 64'd96);
        chk("pin_bpp32_me", e.me, 64'd127);
        chk("pin_bpp32_ce", e.ce, 64'd122);
        e = model(2'd2, 16'd640, 32'h0, 16'd5, 16'd2);
        chk("pin_bpp24_addr", e.addr, 64'hF00);
        chk("pin_bpp24_mb", e.mb, 64'd112);
        chk("pin_bpp24_me_wrap", e.me, 64'd7);
        chk("pin_bpp24_ce_wrap", e.ce, 64'd4);
        e = model(2'd1, 16'd800, 32'h0, 16'd0, 16'd1);
        chk("pin_w800_addr", e.addr, 64'h640);
        chk("pin_w800_me", e.me, 64'd15);

        repeat (3) @(posedge clk);
        release_reset();

        send(32'h1000_0000, 16'd10, 16'd3, w);
        idle(6);

        color_depth_i = 2'd3;
        send(32'h0, 16'd7, 16'd0, w);
        idle(6);

        // Eight back-to-back requests must each be taken without waiting.
        for (int i = 0; i < 8; i++) begin
            send(32'($urandom), 16'($urandom), 16'($urandom_range(0, 479)), w);
            if (i > 0) chk("burst_no_wait", 64'(w), 64'd0);
        end
        idle(6);

        for (int i = 0; i < 3; i++) send(32'($urandom), 16'($urandom), 16'(i + 1), w);
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
        end
        out_ready_i = 1'b1;
        idle(10);

        color_depth_i = 2'd1;
        bmp_width_i   = 16'd640;
        send(32'h0, 16'd10, 16'd3, w);
        send(32'h0, 16'd20, 16'd5, w);
        bmp_width_i    = 16'd800;
        base_address_i = '0;
        x_coord_i      = 16'd0;
        y_coord_i      = 16'd1;
        in_valid_i     = 1'b1;
        @(negedge clk);
        chk("chg_busy_same_cycle", 64'(cfg_busy_o), 64'd0);
        chk("chg_in_ready", 64'(in_ready_o), 64'd0);
        busy_n    = 0;
        last_out  = -1;
        first_rdy = -1;
        for (int i = 0; i < 20 && first_rdy < 0; i++) begin
            @(negedge clk);
            if (out_valid_o) last_out = cyc;
            if (in_ready_o) first_rdy = cyc;
            else if (cfg_busy_o) busy_n++;
        end
        chk("drain_gap", 64'(first_rdy - last_out), 64'd3);
        chk("drain_busy_cycles", 64'(busy_n), 64'd4);
        @(posedge clk); #1;
        idle(6);

        for (int i = 0; i < 3; i++) send(32'($urandom), 16'($urandom), 16'(i), w);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        release_reset();
        idle(10);

        for (int i = 0; i < 3000; i++) begin
            in_valid_i     = ($urandom_range(0, 3) != 32'd0);
            base_address_i = 32'($urandom);
            x_coord_i      = 16'($urandom);
            y_coord_i      = 16'($urandom);
            out_ready_i    = ($urandom_range(0, 3) != 32'd0);
            if ($urandom_range(0, 199) == 32'd0) begin
                color_depth_i = 2'($urandom_range(0, 3));
                bmp_width_i   = 16'($urandom_range(1, 4096));
            end
            @(posedge clk); #1;
        end

        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        for (int i = 0; i < 50 && q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        chk("final_queue_empty", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
